keyboard_note_tracker: RTL

- Parametrised successor to the scan-code-to-note decoder.
- Consumes PS/2 set-2 scan bytes qualified by a one-cycle valid strobe and tracks make/break state with a prefix FSM (F0 break, E0 extended).
- Maintains a held-note bitmap of NOTES keys, a saturating octave register driven by Z/X keys, and a held-note count.
- Sits between the PS/2 receiver and the tone generators/mixer.

---
 rtl/keyboard_pkg.sv | 32 +++
 rtl/scan_note_lookup.sv | 31 +++
 rtl/keyboard_note_tracker.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/keyboard_pkg.sv
// ============================================================================
// keyboard_pkg : scan codes, note key map and prefix-FSM states shared by
//                the keyboard note tracker.
// Rev 1.0
// ============================================================================
`default_nettype none

package keyboard_pkg;

   localparam logic [7:0] SC_BREAK   = 8'hF0;
   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam logic [7:0] SC_OCT_DN  = 8'h1A;
   localparam logic [7:0] SC_OCT_UP  = 8'h22;
   localparam logic [7:0] SC_SUSTAIN = 8'h29;

   localparam int KEY_MAP_LEN = 13;
   localparam int NOTE_IDX_W  = 4;

   // Index 0 is the leftmost entry: C4 up to C5.
   localparam logic [0:KEY_MAP_LEN-1][7:0] NOTE_KEY_MAP = {
      8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
      8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42
   };

   localparam logic [1:0] S_WAIT   = 2'd0;
   localparam logic [1:0] S_BRK    = 2'd1;
   localparam logic [1:0] S_EXT    = 2'd2;
   localparam logic [1:0] S_EXTBRK = 2'd3;

endpackage

`default_nettype wire

// File: rtl/scan_note_lookup.sv
// ============================================================================
// scan_note_lookup : combinational scan code -> {hit, note index}; entries
//                    at or above NOTES report no hit.
// Rev 1.0
// ============================================================================
`default_nettype none

module scan_note_lookup
   import keyboard_pkg::*;
#(
   parameter int NOTES = 13
) (
   input  logic [7:0]            code,
   output logic                  hit,
   output logic [NOTE_IDX_W-1:0] index
);

   always_comb begin
      hit   = 1'b0;
      index = '0;
      for (int i = 0; i < NOTES; i++) begin
         if (code == NOTE_KEY_MAP[i]) begin
            hit   = 1'b1;
            index = NOTE_IDX_W'(i);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/keyboard_note_tracker.sv
// ============================================================================
// keyboard_note_tracker : PS/2 set-2 make/break tracker producing a held-note
//                         bitmap, saturating octave and held-note count.
// Optional feature macro: KEYBOARD_NOTE_TRACKER_SUSTAIN_EN (space = sustain).
// Rev 1.0
// ============================================================================
`default_nettype none

module keyboard_note_tracker
   import keyboard_pkg::*;
#(
   parameter int NOTES     = 13,
   parameter int OCT_BITS  = 3,
   parameter int OCT_RESET = 4,
   parameter int OCT_MAX   = 7
) (
   input  logic                       clk_50Mhz,
   input  logic                       rst_n,
   input  logic                       idle,
   input  logic [7:0]                 code,
   input  logic                       code_valid,
   output logic [NOTES-1:0]           sound,
   output logic [OCT_BITS-1:0]        octave,
   output logic [$clog2(NOTES+1)-1:0] note_count,
   output logic                       key_event
`ifdef KEYBOARD_NOTE_TRACKER_SUSTAIN_EN
   ,
   output logic                       sustain
`endif
);

   localparam int CNT_W = $clog2(NOTES+1);

   logic [1:0]            state, state_nxt;
   logic [NOTES-1:0]      sound_nxt;
   logic [OCT_BITS-1:0]   octave_nxt;
   logic [CNT_W-1:0]      count_nxt;
   logic                  dn_held, dn_held_nxt;
   logic                  up_held, up_held_nxt;
   logic                  hit;
   logic [NOTE_IDX_W-1:0] idx;
   logic [NOTES-1:0]      key_mask;
`ifdef KEYBOARD_NOTE_TRACKER_SUSTAIN_EN
   logic [NOTES-1:0]      phys, phys_nxt;
   logic                  sustain_nxt;
`endif

   scan_note_lookup #(.NOTES(NOTES)) u_lookup (
      .code  (code),
      .hit   (hit),
      .index (idx)
   );

   assign key_mask = hit ? (NOTES'(1) << idx) : '0;

   always_comb begin
      state_nxt   = state;
      sound_nxt   = sound;
      octave_nxt  = octave;
      dn_held_nxt = dn_held;
      up_held_nxt = up_held;
`ifdef KEYBOARD_NOTE_TRACKER_SUSTAIN_EN
      phys_nxt    = phys;
      sustain_nxt = sustain;
`endif
      if (idle) begin
         state_nxt   = S_WAIT;
         sound_nxt   = '0;
         dn_held_nxt = 1'b0;
         up_held_nxt = 1'b0;
`ifdef KEYBOARD_NOTE_TRACKER_SUSTAIN_EN
         phys_nxt    = '0;
         sustain_nxt = 1'b0;
`endif
      end else if (code_valid) begin
         case (state)
            S_WAIT: begin
               if (code == SC_BREAK) begin
                  state_nxt = S_BRK;
               end else if (code == SC_EXT) begin
                  state_nxt = S_EXT;
               end else begin
                  sound_nxt = sound | key_mask;
`ifdef KEYBOARD_NOTE_TRACKER_SUSTAIN_EN
                  phys_nxt  = phys | key_mask;
                  if (code == SC_SUSTAIN) sustain_nxt = 1'b1;
`endif
                  // Held flags make typematic repeats shift the octave once.
                  if (code == SC_OCT_DN && !dn_held) begin
                     dn_held_nxt = 1'b1;
                     if (octave != '0) octave_nxt = octave - OCT_BITS'(1);
                  end
                  if (code == SC_OCT_UP && !up_held) begin
                     up_held_nxt = 1'b1;
                     if (octave != OCT_BITS'(OCT_MAX)) octave_nxt = octave + OCT_BITS'(1);
                  end
               end
            end
            S_BRK: begin
               state_nxt = S_WAIT;
`ifdef KEYBOARD_NOTE_TRACKER_SUSTAIN_EN
               phys_nxt = phys & ~key_mask;
               if (!sustain) sound_nxt = sound & ~key_mask;
               if (code == SC_SUSTAIN) begin
                  sustain_nxt = 1'b0;
                  sound_nxt   = phys_nxt;
               end
`else
               sound_nxt = sound & ~key_mask;
`endif
               if (code == SC_OCT_DN) dn_held_nxt = 1'b0;
               if (code == SC_OCT_UP) up_held_nxt = 1'b0;
            end
            S_EXT:    state_nxt = (code == SC_BREAK) ? S_EXTBRK : S_WAIT;
            default:  state_nxt = S_WAIT;
         endcase
      end
   end

   always_comb begin
      count_nxt = '0;
      for (int i = 0; i < NOTES; i++) begin
         count_nxt = count_nxt + CNT_W'(sound_nxt[i]);
      end
   end

   always_ff @(posedge clk_50Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_WAIT;
         sound      <= '0;
         octave     <= OCT_BITS'(OCT_RESET);
         note_count <= '0;
         key_event  <= 1'b0;
         dn_held    <= 1'b0;
         up_held    <= 1'b0;
`ifdef KEYBOARD_NOTE_TRACKER_SUSTAIN_EN
         phys       <= '0;
         sustain    <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         sound      <= sound_nxt;
         octave     <= octave_nxt;
         note_count <= count_nxt;
         key_event  <= (sound_nxt != sound) || (octave_nxt != octave);
         dn_held    <= dn_held_nxt;
         up_held    <= up_held_nxt;
`ifdef KEYBOARD_NOTE_TRACKER_SUSTAIN_EN
         phys       <= phys_nxt;
         sustain    <= sustain_nxt;
`endif
      end
   end

endmodule

`default_nettype wire
